mlp_scheduler: RTL and testbench
================================

MLP_SCHEDULER -- requirements
Module: mlp_scheduler

Interface
REQ-001 Parameter N_HID, default 4, sets the hidden-neuron count; the legal range is 1..6.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  inference request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running inference.
REQ-006 pattern  input  16  4x4 binary pixel grid; bit i is pixel i.
REQ-007 rom_en  output  1  weight ROM read enable.
REQ-008 rom_addr  output  7  weight ROM address.
REQ-009 rom_data  input  8  signed weight, valid the cycle after an enabled address.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE is exited.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  2  classification: 00 = empty, 01 = O, 10 = X, 11 = tie.
REQ-013 score_o, score_x  output  20 each  signed output-neuron sums.

Function
REQ-014 FSM states: IDLE, L1_ADDR, L1_ACC, L1_ACT, L2_ADDR, L2_ACC, L2_STORE, DECIDE, DONE.
REQ-015 IDLE with start=1 and pattern!=0: latch pattern, clear acc, set k=i=0, go to L1_ADDR.
REQ-016 IDLE with start=1 and pattern==0: go to DONE, set result=00 and scores=0, issue no ROM reads.
REQ-017 ROM layout: hidden k, index i (0..15 = weight, 16 = bias) at address k*17+i.
REQ-018 ROM layout: output c (0 = O, 1 = X), index j (0..N_HID-1 = weight, N_HID = bias) at address N_HID*17 + c*(N_HID+1) + j.
REQ-019 ADDR states: rom_en=1 and rom_addr set per REQ-017/018; all other states: rom_en=0, rom_addr=0.
REQ-020 Each ADDR state is followed by exactly one ACC state; no read pipelining.
REQ-021 L1_ACC with i<16: acc += pattern[i] ? sext(rom_data) : 0.
REQ-022 L1_ACC with i=16: acc += sext(rom_data), then go to L1_ACT.
REQ-023 L1_ACC with i<16: i++, return to L1_ADDR.
REQ-024 L1_ACT: h[k] = 0 if acc<0, 127 if acc>127, otherwise acc[6:0]; clear acc and i.
REQ-025 L1_ACT exit: k++ and go to L1_ADDR if k<N_HID-1; otherwise go to L2_ADDR with c=j=0.
REQ-026 L2_ACC with j<N_HID: acc += h[j] (unsigned 7b) * rom_data (signed 8b), 15-bit signed product, sign-extended.
REQ-027 L2_ACC with j=N_HID: acc += sext(rom_data), then go to L2_STORE.
REQ-028 L2_STORE: c=0 stores score_o, c=1 stores score_x; clear acc, j=0.
REQ-029 L2_STORE exit: c=0 goes to L2_ADDR with c=1; c=1 goes to DECIDE.
REQ-030 Accumulator is 20-bit signed; no overflow is possible within the parameter range.
REQ-031 DECIDE: result = 01 if score_o>score_x, 10 if score_x>score_o, 11 if equal (signed compare).
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE.
REQ-033 Latency: start accepted at edge E0 gives done high in the cycle after edge E0+39*N_HID+7 (E0+163 for N_HID=4).
REQ-034 start while not in IDLE is ignored; start in the DONE cycle is ignored.
REQ-035 abort in any busy state: next state IDLE, busy=0, no done pulse, result and scores keep their prior values.
REQ-036 abort has priority over all other transitions.
REQ-037 result and scores change only in DECIDE, in IDLE on the empty-pattern path, or on reset.

Reset
REQ-038 rst low forces state IDLE immediately, regardless of current state.
REQ-039 rst low clears busy, done, rom_en, rom_addr, result, score_o, score_x, acc, all h[] and all counters to 0.
REQ-040 After rst deasserts, the first start is processed normally.

Verification
REQ-041 All-zero ROM, pattern=0x0001, start pulse -> busy next cycle; done at E0+163; scores 0; result=11.
REQ-042 Hidden weights +1, biases 0; O weights +1; X weights -1; pattern=0xFFFF -> h=16 each; score_o=64, score_x=-64, result=01.
REQ-043 Hidden weights/bias 127; O weights/bias 127; X weights/bias -128; pattern=0xFFFF -> h=127; score_o=64643, score_x=-65152, result=01.
REQ-044 pattern=0x0000 with start -> done one cycle after E0; result=00; rom_en never asserted.
REQ-045 Second start at E0+10 ignored; abort at E0+50 -> busy=0 next cycle, no done, result holds prior value; a fresh start completes in 163 cycles.
REQ-046 rst low at E0+80 -> all outputs 0 immediately; after release, REQ-042 stimulus reproduces REQ-042 results.

Source files
------------

// File: rtl/mlp_scheduler.sv
// mlp_scheduler: sequences a 16-input, N_HID-hidden, 2-output MLP inference over a single-port weight ROM.
module mlp_scheduler #(
    parameter int N_HID = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] pattern,
    output logic        rom_en,
    output logic [6:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [19:0] score_o,
    output logic [19:0] score_x
);
    typedef enum logic [3:0] {
        IDLE, L1_ADDR, L1_ACC, L1_ACT, L2_ADDR, L2_ACC, L2_STORE, DECIDE, DONE
    } state_t;

    localparam logic [2:0] K_LAST = 3'(N_HID - 1);
    localparam logic [2:0] J_BIAS = 3'(N_HID);

    state_t state, state_nx;
    logic [15:0] pat;
    logic signed [19:0] acc, so_r, sx_r;
    logic [6:0] h [8];
    logic [2:0] k, j;
    logic [4:0] i;
    logic c;
    logic kill;
    logic signed [15:0] prod;
    logic signed [19:0] w_ext, p_ext;

    assign kill  = abort && (state != IDLE);
    assign w_ext = {{12{rom_data[7]}}, rom_data};
    assign prod  = $signed({1'b0, h[j]}) * $signed(rom_data);
    assign p_ext = {{4{prod[15]}}, prod};

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign rom_en   = (state == L1_ADDR) || (state == L2_ADDR);
    assign rom_addr = (state == L1_ADDR) ? 7'(17 * k + i) :
                      (state == L2_ADDR) ? 7'(N_HID * 17 + (c ? N_HID + 1 : 0) + j) : 7'd0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = !start ? IDLE : (pattern != 16'd0) ? L1_ADDR : DONE;
            L1_ADDR:  state_nx = L1_ACC;
            L1_ACC:   state_nx = (i == 5'd16) ? L1_ACT : L1_ADDR;
            L1_ACT:   state_nx = (k == K_LAST) ? L2_ADDR : L1_ADDR;
            L2_ADDR:  state_nx = L2_ACC;
            L2_ACC:   state_nx = (j == J_BIAS) ? L2_STORE : L2_ADDR;
            L2_STORE: state_nx = c ? DECIDE : L2_ADDR;
            DECIDE:   state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
        if (kill)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Abort freezes the datapath so visible results keep their prior values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat     <= '0;
            acc     <= '0;
            so_r    <= '0;
            sx_r    <= '0;
            k       <= '0;
            j       <= '0;
            i       <= '0;
            c       <= 1'b0;
            result  <= '0;
            score_o <= '0;
            score_x <= '0;
            for (int n = 0; n < 8; n++)
                h[n] <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (start) begin
                    if (pattern != 16'd0) begin
                        pat <= pattern;
                        acc <= '0;
                        k   <= '0;
                        i   <= '0;
                    end else begin
                        result  <= 2'b00;
                        score_o <= '0;
                        score_x <= '0;
                    end
                end
                L1_ACC: begin
                    acc <= acc + ((i == 5'd16 || pat[i[3:0]]) ? w_ext : 20'sd0);
                    i   <= i + 5'd1;
                end
                L1_ACT: begin
                    h[k] <= acc[19] ? 7'd0 : (acc > 20'sd127) ? 7'd127 : acc[6:0];
                    acc  <= '0;
                    i    <= '0;
                    k    <= k + 3'd1;
                    c    <= 1'b0;
                    j    <= '0;
                end
                L2_ACC: begin
                    acc <= acc + ((j == J_BIAS) ? w_ext : p_ext);
                    j   <= j + 3'd1;
                end
                L2_STORE: begin
                    if (c)
                        sx_r <= acc;
                    else
                        so_r <= acc;
                    acc <= '0;
                    j   <= '0;
                    c   <= 1'b1;
                end
                DECIDE: begin
                    score_o <= so_r;
                    score_x <= sx_r;
                    result  <= (so_r > sx_r) ? 2'b01 : (sx_r > so_r) ? 2'b10 : 2'b11;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_scheduler.sv
// tb_mlp_scheduler: randomized and directed checks of mlp_scheduler against a plain-arithmetic MLP model.
module tb_mlp_scheduler;
    localparam int N = 4;
    localparam int LAT = 39 * N + 7;
    localparam int READS = 17 * N + 2 * (N + 1);

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] pattern = '0;
    logic        rom_en, busy, done;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  result;
    logic [19:0] score_o, score_x;
    logic signed [7:0] rom [128];
    int total = 0, bad = 0;
    int last_so = 0, last_sx = 0;
    logic [1:0] last_r = 2'b00;

    mlp_scheduler #(.N_HID(N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .result(result), .score_o(score_o), .score_x(score_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) rom_data <= 8'h00;
        else      rom_data <= rom_en ? rom[rom_addr] : 8'h00;

    function automatic void model(input logic [15:0] p, output int so, output int sx, output logic [1:0] r);
        int hv [N];
        int a;
        for (int n = 0; n < N; n++) begin
            a = int'(rom[n * 17 + 16]);
            for (int b = 0; b < 16; b++)
                if (p[b]) a += int'(rom[n * 17 + b]);
            hv[n] = a < 0 ? 0 : a > 127 ? 127 : a;
        end
        so = int'(rom[N * 17 + N]);
        sx = int'(rom[N * 17 + 2 * N + 1]);
        for (int n = 0; n < N; n++) begin
            so += hv[n] * int'(rom[N * 17 + n]);
            sx += hv[n] * int'(rom[N * 17 + N + 1 + n]);
        end
        if (p == 16'd0) begin
            so = 0;
            sx = 0;
        end
        r = (p == 16'd0) ? 2'b00 : so > sx ? 2'b01 : sx > so ? 2'b10 : 2'b11;
    endfunction

    task automatic fill_const(input int hw, input int hb, input int ow, input int ob, input int xw, input int xb);
        for (int a = 0; a < 128; a++) rom[a] = 8'($urandom);
        for (int n = 0; n < N; n++) begin
            for (int b = 0; b < 16; b++) rom[n * 17 + b] = 8'(hw);
            rom[n * 17 + 16] = 8'(hb);
            rom[N * 17 + n] = 8'(ow);
            rom[N * 17 + N + 1 + n] = 8'(xw);
        end
        rom[N * 17 + N] = 8'(ob);
        rom[N * 17 + 2 * N + 1] = 8'(xb);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++)
            rom[a] = (a < 17 * N) ? 8'($urandom_range(0, 40) - 20) : 8'($urandom);
    endtask

    task automatic run(input logic [15:0] p, input string name);
        int so, sx, cyc, reads, exp_lat, exp_reads;
        logic [1:0] r;
        model(p, so, sx, r);
        exp_lat   = (p == 16'd0) ? 0 : LAT;
        exp_reads = (p == 16'd0) ? 0 : READS;
        @(negedge clk);
        start = 1'b1;
        pattern = p;
        @(negedge clk);
        start = 1'b0;
        pattern = 16'($urandom);
        cyc = 0;
        reads = 0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
        while (done !== 1'b1 && cyc < 1000) begin
            if (rom_en) reads++;
            if (cyc == 10) start = 1'b1;
            if (cyc == 11) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_lat); end
        total++;
        if (reads !== exp_reads) begin bad++; $display("FAIL %s rom_reads got=%0d want=%0d", name, reads, exp_reads); end
        total++;
        if (result !== r) begin bad++; $display("FAIL %s result got=%b want=%b", name, result, r); end
        total++;
        if (int'($signed(score_o)) !== so) begin bad++; $display("FAIL %s score_o got=%0d want=%0d", name, $signed(score_o), so); end
        total++;
        if (int'($signed(score_x)) !== sx) begin bad++; $display("FAIL %s score_x got=%0d want=%0d", name, $signed(score_x), sx); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy); end
        last_so = so;
        last_sx = sx;
        last_r  = r;
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if ({busy, done, rom_en, rom_addr, result, score_o, score_x} !== '0) begin
            bad++;
            $display("FAIL %s outputs busy=%b done=%b rom_en=%b addr=%0d result=%b so=%0d sx=%0d want all 0",
                     name, busy, done, rom_en, rom_addr, result, score_o, score_x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_held");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_zero_rom();
        for (int a = 0; a < 128; a++) rom[a] = 8'sd0;
        run(16'h0001, "zero_rom");
    endtask

    task automatic test_ones();
        fill_const(1, 0, 1, 0, -1, 0);
        run(16'hFFFF, "ones");
        total++;
        if (last_so !== 64 || last_sx !== -64 || last_r !== 2'b01) begin
            bad++;
            $display("FAIL ones_model so=%0d sx=%0d r=%b want 64 -64 01", last_so, last_sx, last_r);
        end
    endtask

    task automatic test_extremes();
        fill_const(127, 127, 127, 127, -128, -128);
        run(16'hFFFF, "extremes");
        total++;
        if (last_so !== 64643 || last_sx !== -65152) begin
            bad++;
            $display("FAIL extremes_model so=%0d sx=%0d want 64643 -65152", last_so, last_sx);
        end
    endtask

    task automatic test_empty();
        fill_random();
        run(16'h0000, "empty");
    endtask

    task automatic test_random();
        logic [15:0] p;
        for (int t = 0; t < 8; t++) begin
            fill_random();
            p = 16'($urandom);
            if (t == 3) p = 16'h0000;
            run(p, $sformatf("random%0d", t));
        end
    endtask

    task automatic test_abort();
        int cyc, seen;
        fill_const(1, 0, 1, 0, -1, 0);
        run(16'hFFFF, "pre_abort");
        fill_random();
        @(negedge clk);
        start = 1'b1;
        pattern = 16'hA5C3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 49) begin
            start = (cyc == 9);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_stop busy=%b done=%b want 0 0", busy, done); end
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort_idle activity_cycles got=%0d want=0", seen); end
        total++;
        if (result !== last_r || int'($signed(score_o)) !== last_so || int'($signed(score_x)) !== last_sx) begin
            bad++;
            $display("FAIL abort_hold result=%b so=%0d sx=%0d want %b %0d %0d",
                     result, $signed(score_o), $signed(score_x), last_r, last_so, last_sx);
        end
        run(16'hA5C3, "after_abort");
    endtask

    task automatic test_reset_midrun();
        fill_const(1, 0, 1, 0, -1, 0);
        @(negedge clk);
        start = 1'b1;
        pattern = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero_outputs("reset_midrun");
        @(negedge clk);
        rst = 1'b1;
        run(16'hFFFF, "post_reset");
    endtask

    initial begin
        test_reset();
        test_zero_rom();
        test_ones();
        test_extremes();
        test_empty();
        test_random();
        test_abort();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
